bram_port_arbiter: RTL and testbench

- Shares the single BRAM wrapper port between two requesters: m0, the front-panel read/write state machine, and m1, a bulk loader or debug master.
- Serialises accesses with round-robin arbitration and a req/ack handshake.
- Drives the wrapper's active-low enable and 4-bit byte write enable.
- Waits out the BRAM read latency and returns registered read data to the granted requester.

---
 rtl/bram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Lets two requesters share the single port of a BRAM wrapper. m0 is the
// front-panel read/write state machine and m1 is a bulk loader or debug master.
// Accesses are serialised with round-robin arbitration and a req/ack handshake.
// The arbiter drives the wrapper's active-low enable and byte write enables,
// waits out the read latency, and returns registered read data to the
// requester that was granted.
//
// Parameters
//   ADDR_W : requester word-address width (zero-extended to 32 bits, <= 32)
//   RD_LAT : BRAM read latency, enable cycle to valid dout (1..4)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   mN_req/we/be/addr/wdata     requester N command (sampled only at grant)
//   mN_ack                      one-cycle completion pulse for requester N
//   mN_rdata                    read data, held until N's next read completes
//   bram_addr/din/we/en         to the wrapper (en is active low)
//   bram_dout                   from the wrapper
//   busy                        high whenever the arbiter is not IDLE
//   owner                       index of the current or last granted requester
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,

  output logic [31:0]       bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout,
  output logic              bram_en,
  output logic [3:0]        bram_we,

  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state, state_nxt;

  // Command register: everything the access needs, captured at grant so the
  // requester may change its inputs freely afterwards.
  logic        cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        owner_q;
  logic [1:0]  wait_cnt;

  logic        grant_valid;
  logic        grant_idx;

  // ---------------------------------------------------------------------------
  // Next-state and grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_idx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_valid = 1'b1;
          // Contention goes to whoever did not have the last grant; otherwise
          // the single requester present wins (m1_req alone selects 1).
          grant_idx   = (m0_req && m1_req) ? ~owner_q : m1_req;
          state_nxt   = ISSUE;
        end
      end
      ISSUE:   state_nxt = cmd_we ? ACK : WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, command register, wait counter and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner_q   <= 1'b1;  // so m0 wins the first contention
      wait_cnt  <= 2'd0;
      cmd_we    <= 1'b0;
      cmd_be    <= 4'h0;
      cmd_addr  <= 32'h0;
      cmd_wdata <= 32'h0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;

      if (grant_valid) begin
        owner_q   <= grant_idx;
        cmd_we    <= grant_idx ? m1_we    : m0_we;
        cmd_be    <= grant_idx ? m1_be    : m0_be;
        cmd_addr  <= grant_idx ? 32'(m1_addr) : 32'(m0_addr);
        cmd_wdata <= grant_idx ? m1_wdata : m0_wdata;
      end

      // The counter is loaded with RD_LAT-1 so WAIT lasts exactly RD_LAT cycles.
      if (state == ISSUE && !cmd_we) begin
        wait_cnt <= 2'(RD_LAT - 1);
      end else if (state == WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end

      if (state == WAIT && wait_cnt == 2'd0) begin
        if (owner_q) m1_rdata <= bram_dout;
        else         m0_rdata <= bram_dout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state. The wrapper is only enabled during ISSUE;
  // address and data come straight from the command register, which only
  // changes at grant, so they hold their last values everywhere else.
  // ---------------------------------------------------------------------------
  assign bram_addr = cmd_addr;
  assign bram_din  = cmd_wdata;
  assign bram_en   = (state != ISSUE);
  assign bram_we   = (state == ISSUE && cmd_we) ? cmd_be : 4'h0;

  assign m0_ack    = (state == ACK) && !owner_q;
  assign m1_ack    = (state == ACK) &&  owner_q;

  assign busy      = (state != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Two arbiter instances (RD_LAT=1 and RD_LAT=3), each with a behavioural BRAM.
// Stimulus tasks push the expected ISSUE cycle and expected ack into
// per-requester queues; monitors pop and compare whenever the DUT enables
// the BRAM or raises an ack.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  typedef struct {
    int          at;    // posedge number that samples the event
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
  } iss_t;

  typedef struct {
    int          at;
    bit          rd;
    logic [31:0] rdata;
  } ack_t;

  logic        clk;
  logic        reset;
  int          cyc;
  int          checks;
  int          errors;

  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [3:0]  be_s    [2][2];
  logic [31:0] addr_s  [2][2];
  logic [31:0] wdata_s [2][2];
  logic        ack     [2][2];
  logic [31:0] rdata   [2][2];

  logic [31:0] b_addr [2];
  logic [31:0] b_din  [2];
  logic [31:0] b_dout [2];
  logic        b_en   [2];
  logic [3:0]  b_we   [2];
  logic        busy   [2];
  logic        owner  [2];

  iss_t iss_q [4][$];
  ack_t ack_q [4][$];

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs, BRAM models and monitors
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [31:0] mem  [256];
    logic [31:0] pipe [4];

    bram_port_arbiter #(.ADDR_W(32), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (req_s[g][0]),
      .m0_we     (we_s[g][0]),
      .m0_be     (be_s[g][0]),
      .m0_addr   (addr_s[g][0]),
      .m0_wdata  (wdata_s[g][0]),
      .m0_ack    (ack[g][0]),
      .m0_rdata  (rdata[g][0]),
      .m1_req    (req_s[g][1]),
      .m1_we     (we_s[g][1]),
      .m1_be     (be_s[g][1]),
      .m1_addr   (addr_s[g][1]),
      .m1_wdata  (wdata_s[g][1]),
      .m1_ack    (ack[g][1]),
      .m1_rdata  (rdata[g][1]),
      .bram_addr (b_addr[g]),
      .bram_din  (b_din[g]),
      .bram_dout (b_dout[g]),
      .bram_en   (b_en[g]),
      .bram_we   (b_we[g]),
      .busy      (busy[g]),
      .owner     (owner[g])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Read-first BRAM with an LAT-deep output pipeline.
    always @(posedge clk) begin
      if (!b_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (b_we[g][b]) mem[b_addr[g][7:0]][8*b +: 8] <= b_din[g][8*b +: 8];
      end
      pipe[0] <= !b_en[g] ? mem[b_addr[g][7:0]] : 32'h0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign b_dout[g] = pipe[LAT-1];

    always @(negedge clk) begin
      int   hit;
      iss_t it;
      ack_t at;
      if (!reset) begin
        if (ack[g][0] || ack[g][1])
          check($sformatf("one_ack_i%0d", g), {31'h0, ack[g][0] & ack[g][1]}, 32'h0);
        for (int m = 0; m < 2; m++) begin
          if (ack[g][m]) begin
            check($sformatf("ack_expected_i%0d_m%0d", g, m),
                  {31'h0, ack_q[g*2+m].size() != 0}, 32'h1);
            if (ack_q[g*2+m].size() != 0) begin
              at = ack_q[g*2+m].pop_front();
              check($sformatf("ack_cycle_i%0d_m%0d", g, m), cyc + 1, at.at);
              if (at.rd) check($sformatf("rdata_i%0d_m%0d", g, m), rdata[g][m], at.rdata);
            end
          end
        end
        if (!b_en[g]) begin
          hit = -1;
          for (int m = 0; m < 2; m++)
            if (hit < 0 && iss_q[g*2+m].size() != 0 && iss_q[g*2+m][0].at == cyc + 1) hit = m;
          check($sformatf("issue_expected_i%0d", g), {31'h0, hit >= 0}, 32'h1);
          if (hit >= 0) begin
            it = iss_q[g*2+hit].pop_front();
            check($sformatf("issue_addr_i%0d", g),  b_addr[g], it.addr);
            check($sformatf("issue_din_i%0d", g),   b_din[g],  it.din);
            check($sformatf("issue_we_i%0d", g),    {28'h0, b_we[g]}, {28'h0, it.we});
            check($sformatf("issue_owner_i%0d", g), {31'h0, owner[g]}, hit);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One access: push expectations, drive the request, wait for ack, drop req.
  // wait_n is the hand-computed number of edges the request waits before grant.
  // ---------------------------------------------------------------------------
  task automatic acc(int g, int m, bit we, logic [3:0] be, logic [31:0] addr,
                     logic [31:0] wdata, logic [31:0] exp_rdata, int wait_n);
    int   grant;
    bit   seen;
    iss_t it;
    ack_t at;
    grant   = cyc + 1 + wait_n;
    it.at   = grant + 1;
    it.addr = addr;
    it.din  = wdata;
    it.we   = we ? be : 4'h0;
    iss_q[g*2+m].push_back(it);
    at.at    = grant + 2 + (we ? 0 : lat(g));
    at.rd    = !we;
    at.rdata = exp_rdata;
    ack_q[g*2+m].push_back(at);

    req_s[g][m]   = 1'b1;
    we_s[g][m]    = we;
    be_s[g][m]    = be;
    addr_s[g][m]  = addr;
    wdata_s[g][m] = wdata;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (ack[g][m]) seen = 1'b1;
    end
    check($sformatf("ack_seen_i%0d_m%0d", g, m), {31'h0, seen}, 32'h1);
    @(negedge clk);
    req_s[g][m] = 1'b0;
  endtask

  task automatic reset_state_checks(int g);
    check($sformatf("rst_busy_i%0d", g),   {31'h0, busy[g]},  32'h0);
    check($sformatf("rst_owner_i%0d", g),  {31'h0, owner[g]}, 32'h1);
    check($sformatf("rst_en_i%0d", g),     {31'h0, b_en[g]},  32'h1);
    check($sformatf("rst_we_i%0d", g),     {28'h0, b_we[g]},  32'h0);
    check($sformatf("rst_m0_ack_i%0d", g), {31'h0, ack[g][0]}, 32'h0);
    check($sformatf("rst_m1_ack_i%0d", g), {31'h0, ack[g][1]}, 32'h0);
    check($sformatf("rst_m0_rd_i%0d", g),  rdata[g][0], 32'h0);
    check($sformatf("rst_m1_rd_i%0d", g),  rdata[g][1], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    iss_t it;
    int   left;
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int m = 0; m < 2; m++) begin
        req_s[g][m] = 1'b0; we_s[g][m] = 1'b0; be_s[g][m] = 4'h0;
        addr_s[g][m] = 32'h0; wdata_s[g][m] = 32'h0;
      end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      reset_state_checks(g);
      check($sformatf("rst_addr_i%0d", g), b_addr[g], 32'h0);
      check($sformatf("rst_din_i%0d", g),  b_din[g],  32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    // ---- Instance 0 (RD_LAT=1): write, read, byte write, zero-byte write ----
    acc(0, 0, 1'b1, 4'hF,    32'h10, 32'hDEAD_BEEF, 32'h0,          0);
    acc(0, 0, 1'b0, 4'h0,    32'h10, 32'h0,         32'hDEAD_BEEF,  0);
    acc(0, 0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, 32'h0,          0);
    acc(0, 0, 1'b0, 4'h0,    32'h10, 32'h0,         32'hDE22_BE44,  0);
    acc(0, 1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 32'h0,          0);
    acc(0, 1, 1'b0, 4'h0,    32'h10, 32'h0,         32'hDE22_BE44,  0);

    // ---- Instance 1 (RD_LAT=3): contention straight after reset ----
    fork
      begin
        acc(1, 0, 1'b1, 4'hF, 32'h20, 32'hA0A0_0001, 32'h0, 0);
        acc(1, 0, 1'b1, 4'hF, 32'h22, 32'hA0A0_0002, 32'h0, 3);
      end
      begin
        acc(1, 1, 1'b1, 4'hF, 32'h21, 32'hB1B1_0001, 32'h0, 3);
        acc(1, 1, 1'b1, 4'hF, 32'h23, 32'hB1B1_0002, 32'h0, 3);
      end
    join

    acc(1, 0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0,         0);
    acc(1, 0, 1'b0, 4'h0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0);

    // ---- m0 requests during m1's WAIT; its inputs change before and after grant ----
    fork
      acc(1, 1, 1'b0, 4'h0, 32'h21, 32'h0, 32'hB1B1_0001, 0);
      begin
        repeat (2) @(negedge clk);
        req_s[1][0] = 1'b1; we_s[1][0] = 1'b1; be_s[1][0] = 4'hF;
        addr_s[1][0] = 32'h3F; wdata_s[1][0] = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        acc(1, 0, 1'b1, 4'hF, 32'h30, 32'h3030_3030, 32'h0, 2);
      end
      begin
        repeat (7) @(negedge clk);
        addr_s[1][0] = 32'h3E; wdata_s[1][0] = 32'h0BAD_F00D;
        be_s[1][0] = 4'h1; we_s[1][0] = 1'b0;
      end
    join
    acc(1, 0, 1'b0, 4'h0, 32'h30, 32'h0, 32'h3030_3030, 0);

    // ---- Reset during the WAIT of an m1 read, with m0 pending ----
    req_s[1][1] = 1'b1; we_s[1][1] = 1'b0; be_s[1][1] = 4'h0;
    addr_s[1][1] = 32'h10; wdata_s[1][1] = 32'h0;
    it.at = cyc + 2; it.addr = 32'h10; it.din = 32'h0; it.we = 4'h0;
    iss_q[3].push_back(it);
    repeat (2) @(negedge clk);
    req_s[1][0] = 1'b1; we_s[1][0] = 1'b0; addr_s[1][0] = 32'h30;
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset_state_checks(1);
    req_s[1][1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    fork
      acc(1, 0, 1'b0, 4'h0, 32'h30, 32'h0,         32'h3030_3030, 0);
      acc(1, 1, 1'b1, 4'hF, 32'h24, 32'hC0C0_C0C0, 32'h0,         6);
    join

    repeat (4) @(negedge clk);
    left = 0;
    for (int q = 0; q < 4; q++) left += iss_q[q].size() + ack_q[q].size();
    check("queues_drained", left, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
